// File: rtl/conv_window_3x3_pkg.sv
// Shared Conv2d definitions: default geometry and the 3x3 window slot layout.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package conv_window_3x3_pkg;

    localparam int CW_DW    = 32;
    localparam int CW_IMG_W = 32;
    localparam int CW_IMG_H = 32;

    // Bit offset of window element (i,j); the MAC stage uses the same layout.
    function automatic int win_lsb(input int i, input int j, input int dw);
        return (3 * i + j) * dw;
    endfunction

endpackage

// File: rtl/conv_window_3x3_window_line_fifo.sv
// Enable-gated shift delay: dout_o is the word written DEPTH enables earlier.
// Latency: DEPTH enabled cycles; contents frozen while en_i is low.
// Backpressure: none; the owner gates en_i with its own accept.
module window_line_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Shift one slot per enable, newest word enters at slot 0.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
        end
        if (en_i) begin
            mem_d[0] = din_i;
            for (int k = 1; k < DEPTH; k++) begin
                mem_d[k] = mem_q[k-1];
            end
        end
    end

    // Delay storage, cleared on reset so a fresh frame starts from zeros.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator over a raster pixel stream, fully-inside windows only.
// Latency: 1 cycle from accepting pixel (r,c) to the window centred at (r-1,c-1).
// Backpressure: din_ready = !win_valid | win_ready; a held window stalls the input.
module conv_window_3x3
    import conv_window_3x3_pkg::*;
#(
    parameter int DW    = CW_DW,
    parameter int IMG_W = CW_IMG_W,
    parameter int IMG_H = CW_IMG_H
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    input  logic            din_sof,
    output logic            din_ready,
    output logic [9*DW-1:0] window,
    output logic            win_valid,
    input  logic            win_ready,
    output logic            frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic            accept;
    logic [DW-1:0]   line1_out;
    logic [DW-1:0]   line2_out;
    logic [CW-1:0]   col_q, col_d, col_cur;
    logic [RW-1:0]   row_q, row_d, row_cur;
    logic [9*DW-1:0] window_q, window_d;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;

    assign din_ready = !win_valid_q | win_ready;
    assign accept    = din_valid & din_ready;

    // Row r-1 and row r-2 taps, advancing only on accepted pixels.
    window_line_fifo #(.DW(DW), .DEPTH(IMG_W)) u_line1 (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (accept),
        .din_i  (din),
        .dout_o (line1_out)
    );

    window_line_fifo #(.DW(DW), .DEPTH(IMG_W)) u_line2 (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (accept),
        .din_i  (line1_out),
        .dout_o (line2_out)
    );

    // A start-of-frame pixel is position (0,0) regardless of the counters.
    assign col_cur = din_sof ? '0 : col_q;
    assign row_cur = din_sof ? '0 : row_q;

    // Next-state: position counters, window shift, valid and frame-end pulse.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        window_d     = window_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    window_d[win_lsb(i, j, DW) +: DW] = window_q[win_lsb(i, j + 1, DW) +: DW];
                end
            end
            window_d[win_lsb(0, 2, DW) +: DW] = line2_out;
            window_d[win_lsb(1, 2, DW) +: DW] = line1_out;
            window_d[win_lsb(2, 2, DW) +: DW] = din;

            // Column gate keeps windows from straddling a row boundary.
            win_valid_d = (row_cur >= RW'(2)) && (col_cur >= CW'(2));

            if (col_cur == COL_LAST) begin
                col_d = '0;
                if (row_cur == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_cur + RW'(1);
                end
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            window_q     <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            window_q     <= window_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign window     = window_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
module tb_conv_window_3x3;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_sof = 1'b0;
    logic          din_ready;
    logic [WW-1:0] window;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic          frame_done;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;
    logic [WW-1:0] wq[$];

    conv_window_3x3 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_ready  (din_ready),
        .window     (window),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Record every consumed window and every frame_done cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid && win_ready) wq.push_back(window);
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_win(input int base, input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DW +: DW] = DW'(base + W*(r-2+i) + (c-2+j));
        return w;
    endfunction

    // Offer one pixel and hold it until accepted (bounded).
    task automatic send_px(input int d, input logic sof);
        bit took;
        din = DW'(d);
        din_valid = 1'b1;
        din_sof = sof;
        took = 1'b0;
        for (int k = 0; k < 50 && !took; k++) begin
            @(negedge clk);
            took = din_ready;
            @(posedge clk);
            #1;
        end
        if (!took) chk("accept_timeout", 0, 1);
        din_valid = 1'b0;
        din_sof = 1'b0;
    endtask

    task automatic send_frame(input int base, input logic sof, input bit gaps);
        for (int p = 0; p < W*H; p++) begin
            send_px(base + p, sof && (p == 0));
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        fd_cnt = 0;
    endtask

    // Compare four recorded windows starting at index 'first' against a ramp frame.
    task automatic chk_frame(input string tag, input int base, input int first);
        for (int k = 0; k < 4; k++) begin
            logic [WW-1:0] o;
            o = (first + k < wq.size()) ? wq[first + k] : '0;
            chk($sformatf("%s_w%0d", tag, k), o, exp_win(base, 2 + k/2, 2 + k%2));
        end
    endtask

    initial begin
        logic [WW-1:0] pre;
        int pre_vals[9];

        // Reset state.
        idle(3);
        rst_n = 1'b1;
        idle(1);
        chk("rst_window", window, '0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_din_ready", din_ready, 1);

        // Mid-frame reset after 7 pixels.
        for (int p = 0; p < 7; p++) send_px(p, p == 0);
        pre_vals = '{0, 0, 0, 0, 1, 2, 4, 5, 6};
        pre = '0;
        for (int e = 0; e < 9; e++) pre[e*DW +: DW] = DW'(pre_vals[e]);
        chk("pre_reset_window", window, pre);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_window", window, '0);
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_frame_done", frame_done, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Continuous frame after reset, no sof: counters must start at (0,0).
        clear_mon();
        for (int p = 0; p < 10; p++) send_px(p, 1'b0);
        chk("s1_no_win_before_10", win_valid, 0);
        send_px(10, 1'b0);
        chk("s1_first_valid", win_valid, 1);
        chk("s1_first_window", window, exp_win(0, 2, 2));
        for (int p = 11; p < 16; p++) send_px(p, 1'b0);
        idle(3);
        chk("s1_win_count", wq.size(), 4);
        chk_frame("s1", 0, 0);
        chk("s1_frame_done", fd_cnt, 1);

        // din_valid toggled every cycle.
        clear_mon();
        send_frame(0, 1'b1, 1'b1);
        idle(3);
        chk("s2_win_count", wq.size(), 4);
        chk_frame("s2", 0, 0);
        chk("s2_frame_done", fd_cnt, 1);

        // Downstream stall at the first window.
        clear_mon();
        win_ready = 1'b0;
        for (int p = 0; p <= 10; p++) send_px(p, p == 0);
        din = DW'(11);
        din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("s3_din_ready_c%0d", k), din_ready, 0);
            chk($sformatf("s3_win_held_c%0d", k), window, exp_win(0, 2, 2));
            @(posedge clk);
            #1;
        end
        win_ready = 1'b1;
        for (int p = 11; p < 16; p++) send_px(p, 1'b0);
        idle(3);
        chk("s3_win_count", wq.size(), 4);
        chk_frame("s3", 0, 0);

        // Back-to-back frames.
        clear_mon();
        send_frame(0, 1'b1, 1'b0);
        send_frame(16, 1'b1, 1'b0);
        idle(3);
        chk("s4_win_count", wq.size(), 8);
        chk_frame("s4a", 0, 0);
        chk_frame("s4b", 16, 4);
        chk("s4_frame_done", fd_cnt, 2);

        // sof on the 3rd pixel resynchronises the counters.
        clear_mon();
        send_px(200, 1'b1);
        send_px(201, 1'b0);
        for (int p = 0; p < 10; p++) send_px(100 + p, p == 0);
        chk("s6_no_win_after_10", win_valid, 0);
        for (int p = 10; p < 16; p++) send_px(100 + p, 1'b0);
        idle(3);
        chk("s6_win_count", wq.size(), 4);
        chk_frame("s6", 100, 0);
        chk("s6_frame_done", fd_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
